vram_scanout_controller: RTL

// - Read-only consumer of video RAM port B (CPU owns port A via memory_controller).
// - Walks VRAM linearly from VRAM_BASE, unpacks two 8-bit pixels per 16-bit word and

---
 rtl/vram_scanout_pkg.sv | 32 +++
 rtl/vram_scanout_if.sv | 24 ++
 rtl/scanout_timing_generator.sv | 67 ++++++
 rtl/vram_scanout_controller.sv | 135 +++++++++++++
 4 files changed

// File: rtl/vram_scanout_pkg.sv
// Shared types, default raster timing and small helpers for the VRAM scanout controller.
package vram_scanout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scanout_state_t;

    localparam int DEFAULT_H_ACTIVE = 16;
    localparam int DEFAULT_H_FRONT  = 2;
    localparam int DEFAULT_H_SYNC   = 4;
    localparam int DEFAULT_H_BACK   = 2;
    localparam int DEFAULT_V_ACTIVE = 8;
    localparam int DEFAULT_V_FRONT  = 1;
    localparam int DEFAULT_V_SYNC   = 2;
    localparam int DEFAULT_V_BACK   = 1;

    // Raster attributes of one counter position, carried down the alignment pipeline.
    typedef struct packed {
        logic active;
        logic odd;
        logic hsync;
        logic vsync;
        logic frame_start;
    } raster_tap_t;

    function automatic logic sync_level(input logic asserted, input logic active_low);
        return asserted ^ active_low;
    endfunction

endpackage

// File: rtl/vram_scanout_if.sv
// VRAM port-B bus: the scanout controller drives it as master, the video RAM answers as slave.
interface vram_scanout_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
);
    logic                     vram_enable_b;
    logic                     vram_rw_b;
    logic [ADDRESS_WIDTH-1:0] vram_address_b;
    logic [DATA_WIDTH-1:0]    vram_data_b;

    modport master (
        output vram_enable_b,
        output vram_rw_b,
        output vram_address_b,
        input  vram_data_b
    );

    modport slave (
        input  vram_enable_b,
        input  vram_rw_b,
        input  vram_address_b,
        output vram_data_b
    );
endinterface

// File: rtl/scanout_timing_generator.sv
// Horizontal/vertical raster counters with active-area, sync-window and frame-wrap decode.
module scanout_timing_generator
    import vram_scanout_pkg::*;
#(
    parameter int H_ACTIVE = DEFAULT_H_ACTIVE,
    parameter int H_FRONT  = DEFAULT_H_FRONT,
    parameter int H_SYNC   = DEFAULT_H_SYNC,
    parameter int H_BACK   = DEFAULT_H_BACK,
    parameter int V_ACTIVE = DEFAULT_V_ACTIVE,
    parameter int V_FRONT  = DEFAULT_V_FRONT,
    parameter int V_SYNC   = DEFAULT_V_SYNC,
    parameter int V_BACK   = DEFAULT_V_BACK
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic active,
    output logic h_odd,
    output logic hsync_on,
    output logic vsync_on,
    output logic at_origin,
    output logic frame_wrap
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    // One spare count of headroom so the sync-end bound is representable when the back porch is 0.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEGIN = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEGIN = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [HW-1:0] h;
    logic [VW-1:0] v;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (enable) begin
            // NOTE: non-blocking so h and v both update from their pre-edge values.
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    always_comb begin
        active     = (h < H_ACT) && (v < V_ACT);
        h_odd      = h[0];
        hsync_on   = (h >= H_SYNC_BEGIN) && (h < H_SYNC_END);
        vsync_on   = (v >= V_SYNC_BEGIN) && (v < V_SYNC_END);
        at_origin  = (h == '0) && (v == '0);
        frame_wrap = (h == H_LAST) && (v == V_LAST);
    end

endmodule

// File: rtl/vram_scanout_controller.sv
// Reads VRAM port B linearly, unpacks two pixels per word and emits a 2-clock-aligned raster stream.
module vram_scanout_controller
    import vram_scanout_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH   = 16,
    parameter int                       DATA_WIDTH      = 16,
    parameter int                       PIXEL_WIDTH     = 8,
    parameter logic [ADDRESS_WIDTH-1:0] VRAM_BASE       = '0,
    parameter int                       H_ACTIVE        = DEFAULT_H_ACTIVE,
    parameter int                       H_FRONT         = DEFAULT_H_FRONT,
    parameter int                       H_SYNC          = DEFAULT_H_SYNC,
    parameter int                       H_BACK          = DEFAULT_H_BACK,
    parameter int                       V_ACTIVE        = DEFAULT_V_ACTIVE,
    parameter int                       V_FRONT         = DEFAULT_V_FRONT,
    parameter int                       V_SYNC          = DEFAULT_V_SYNC,
    parameter int                       V_BACK          = DEFAULT_V_BACK,
    parameter bit                       SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   run,
    output logic                   busy,
    output logic                   frame_start,
    vram_scanout_if.master         vram,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   pixel_active,
    output logic                   hsync,
    output logic                   vsync
);

    scanout_state_t state, next_state;

    logic counting;
    logic active, h_odd, hsync_on, vsync_on, at_origin, frame_wrap;

    raster_tap_t tap, s1;

    logic [ADDRESS_WIDTH-1:0] pointer;
    logic [PIXEL_WIDTH-1:0]   held_pixel;
    logic [PIXEL_WIDTH-1:0]   pixel_next;

    scanout_timing_generator #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK)
    ) u_timing (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (counting),
        .active     (active),
        .h_odd      (h_odd),
        .hsync_on   (hsync_on),
        .vsync_on   (vsync_on),
        .at_origin  (at_origin),
        .frame_wrap (frame_wrap)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // A stop request only retires at the frame wrap; run at the wrap chains the next frame.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:    if (run) next_state = RUN;
            RUN:     if (!run) next_state = frame_wrap ? IDLE : DRAIN;
            DRAIN:   if (run) next_state = RUN;
                     else if (frame_wrap) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        counting            = (state != IDLE);
        busy                = counting;
        vram.vram_enable_b  = counting && active && !h_odd;
        vram.vram_rw_b      = 1'b0;
        vram.vram_address_b = pointer;
        tap = '{
            active:      counting && active,
            odd:         h_odd,
            hsync:       counting && hsync_on,
            vsync:       counting && vsync_on,
            frame_start: counting && at_origin
        };
    end

    // Advances once per fetched word, i.e. after the odd half of each active pixel pair.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pointer <= VRAM_BASE;
        end else if (counting) begin
            if (frame_wrap)           pointer <= VRAM_BASE;
            else if (active && h_odd) pointer <= pointer + ADDRESS_WIDTH'(1);
        end
    end

    // Stage 1 sees read data for an even pixel; the odd half is parked for the following clock.
    always_comb begin
        pixel_next = '0;
        if (s1.active) begin
            pixel_next = s1.odd ? held_pixel
                                : vram.vram_data_b[DATA_WIDTH-1 -: PIXEL_WIDTH];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1           <= '0;
            held_pixel   <= '0;
            pixel_out    <= '0;
            pixel_active <= 1'b0;
            hsync        <= sync_level(1'b0, SYNC_ACTIVE_LOW);
            vsync        <= sync_level(1'b0, SYNC_ACTIVE_LOW);
            frame_start  <= 1'b0;
        end else begin
            s1 <= tap;
            if (s1.active && !s1.odd) held_pixel <= vram.vram_data_b[PIXEL_WIDTH-1:0];
            pixel_out    <= pixel_next;
            pixel_active <= s1.active;
            hsync        <= sync_level(s1.hsync, SYNC_ACTIVE_LOW);
            vsync        <= sync_level(s1.vsync, SYNC_ACTIVE_LOW);
            frame_start  <= s1.frame_start;
        end
    end

endmodule
